// File: rtl/fetch_ctrl.sv
// Instruction-fetch front end: owns the PC, stalls for a fixed refill time on a cache miss,
// and holds each fetched {pc, instr} in a valid/ready output register. Optional macro:
// FETCH_PERF_CNT_EN adds the saturating hit_cnt/miss_cnt outputs.
module fetch_ctrl #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned INSTR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'hA75D53D8,
    parameter int unsigned PC_STEP      = 4,
    parameter int unsigned MISS_LATENCY = 100
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [ADDR_WIDTH-1:0]  pc,
    input  logic                   cache_hit,
    input  logic [INSTR_WIDTH-1:0] cache_instr,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_WIDTH-1:0]  out_pc,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic                   stall
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]            hit_cnt,
    output logic [31:0]            miss_cnt
`endif
);

    localparam int unsigned CNT_W = (MISS_LATENCY > 1) ? $clog2(MISS_LATENCY) : 1;

    typedef enum logic [0:0] {StFetch, StMissWait} state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic                   out_valid_q, out_valid_d;
    logic [ADDR_WIDTH-1:0]  out_pc_q, out_pc_d;
    logic [INSTR_WIDTH-1:0] out_instr_q, out_instr_d;
    logic                   accept;
    logic                   hit_evt, miss_evt;

    assign accept = !out_valid_q || out_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        hit_evt     = 1'b0;
        miss_evt    = 1'b0;
        if (redirect_valid) begin
            // Flush wins over a same-cycle drain or fetch.
            pc_d        = redirect_pc;
            state_d     = StFetch;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (accept) begin
                        if (cache_hit) begin
                            out_pc_d    = pc_q;
                            out_instr_d = cache_instr;
                            out_valid_d = 1'b1;
                            pc_d        = pc_q + ADDR_WIDTH'(PC_STEP);
                            hit_evt     = 1'b1;
                        end else begin
                            state_d  = StMissWait;
                            cnt_d    = CNT_W'(MISS_LATENCY - 1);
                            miss_evt = 1'b1;
                            if (out_ready) out_valid_d = 1'b0;
                        end
                    end
                end
                StMissWait: begin
                    if (out_ready) out_valid_d = 1'b0;
                    if (cnt_q == '0) state_d = StFetch;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                default: state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StFetch;
            cnt_q       <= '0;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
        end
    end

    assign pc        = pc_q;
    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_instr = out_instr_q;
    assign stall     = (state_q == StMissWait);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // Saturating; only rst clears them, a redirect does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_evt && hit_cnt_q != '1)   hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss_evt && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    logic unused_evt;
    assign unused_evt = hit_evt ^ miss_evt;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: default instance (RESET_PC A75D53D8, 100-cycle miss) plus
// a wrap/short-miss instance (RESET_PC FFFFFFFC, MISS_LATENCY 1).
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cache_hit, redirect_valid, out_ready;
    logic [31:0] redirect_pc;
    logic [31:0] pc, out_pc, out_instr, cache_instr;
    logic        out_valid, stall;
    logic        hit_b;
    logic [31:0] pc_b, out_pc_b, out_instr_b, cache_instr_b;
    logic        out_valid_b, stall_b;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt, hit_cnt_b, miss_cnt_b;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Cache model: instruction is a fixed scramble of its address.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    assign cache_instr   = instr_of(pc);
    assign cache_instr_b = instr_of(pc_b);

    fetch_ctrl u_dut (
        .clk(clk), .rst(rst), .pc(pc), .cache_hit(cache_hit), .cache_instr(cache_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr), .stall(stall)
`ifdef FETCH_PERF_CNT_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC), .MISS_LATENCY(1)) u_dut_b (
        .clk(clk), .rst(rst), .pc(pc_b), .cache_hit(hit_b), .cache_instr(cache_instr_b),
        .redirect_valid(1'b0), .redirect_pc(32'h0), .out_valid(out_valid_b),
        .out_ready(1'b1), .out_pc(out_pc_b), .out_instr(out_instr_b), .stall(stall_b)
`ifdef FETCH_PERF_CNT_EN
        , .hit_cnt(hit_cnt_b), .miss_cnt(miss_cnt_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int stall_len;

    initial begin
        rst = 1'b1; cache_hit = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0;
        redirect_pc = '0; hit_b = 1'b1;
        step(); step();
        check("rst_pc", pc, 32'hA75D53D8);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_stall", {31'b0, stall}, 32'd0);

        // Back-to-back hits
        rst = 1'b0;
        step();
        check("hit1_valid", {31'b0, out_valid}, 32'd1);
        check("hit1_out_pc", out_pc, 32'hA75D53D8);
        check("hit1_instr", out_instr, instr_of(32'hA75D53D8));
        check("hit1_pc", pc, 32'hA75D53DC);
        step();
        check("hit2_out_pc", out_pc, 32'hA75D53DC);
        check("hit2_pc", pc, 32'hA75D53E0);

        // Miss at A75D53E0, 100 stall cycles
        cache_hit = 1'b0;
        step();
        check("miss_stall", {31'b0, stall}, 32'd1);
        check("miss_pc", pc, 32'hA75D53E0);
        check("miss_drain", {31'b0, out_valid}, 32'd0);
        cache_hit = 1'b1;
        stall_len = 1;
        for (int i = 0; i < 200 && stall; i++) begin
            step();
            if (stall) stall_len++;
        end
        check("miss_len", stall_len, 32'd100);
        check("miss_pc_held", pc, 32'hA75D53E0);
        step();
        check("retry_valid", {31'b0, out_valid}, 32'd1);
        check("retry_out_pc", out_pc, 32'hA75D53E0);
        check("retry_pc", pc, 32'hA75D53E4);

        // Backpressure freezes everything
        out_ready = 1'b0;
        repeat (5) step();
        check("bp_valid", {31'b0, out_valid}, 32'd1);
        check("bp_out_pc", out_pc, 32'hA75D53E0);
        check("bp_instr", out_instr, instr_of(32'hA75D53E0));
        check("bp_pc", pc, 32'hA75D53E4);
        out_ready = 1'b1;
        step();
        check("bp_rel1", out_pc, 32'hA75D53E4);
        step();
        check("bp_rel2", out_pc, 32'hA75D53E8);
        check("bp_rel2_pc", pc, 32'hA75D53EC);

        // Miss is not raised while the output register is blocked
        out_ready = 1'b0; cache_hit = 1'b0;
        step();
        check("blk_no_miss", {31'b0, stall}, 32'd0);
        check("blk_pc", pc, 32'hA75D53EC);
        check("blk_out_pc", out_pc, 32'hA75D53E8);
        out_ready = 1'b1;
        step();
        check("miss2_stall", {31'b0, stall}, 32'd1);
        repeat (59) step();
        check("miss2_still", {31'b0, stall}, 32'd1);

        // Redirect at cnt==40
        redirect_valid = 1'b1; redirect_pc = 32'h0000_1000;
        step();
        redirect_valid = 1'b0; cache_hit = 1'b1;
        check("redir_stall", {31'b0, stall}, 32'd0);
        check("redir_pc", pc, 32'h0000_1000);
        check("redir_valid", {31'b0, out_valid}, 32'd0);
        step();
        check("redir_hit_out_pc", out_pc, 32'h0000_1000);
        check("redir_hit_pc", pc, 32'h0000_1004);

        // Redirect flushes a held instruction even while draining
        redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
        step();
        redirect_valid = 1'b0;
        check("flush_valid", {31'b0, out_valid}, 32'd0);
        check("flush_pc", pc, 32'h0000_2000);
`ifdef FETCH_PERF_CNT_EN
        check("hit_cnt", hit_cnt, 32'd6);
        check("miss_cnt", miss_cnt, 32'd2);
`endif

        // Reset in the middle of a miss
        cache_hit = 1'b0;
        step();
        check("miss3_stall", {31'b0, stall}, 32'd1);
        rst = 1'b1;
        step();
        check("rst_mid_stall", {31'b0, stall}, 32'd0);
        check("rst_mid_pc", pc, 32'hA75D53D8);
        check("rst_mid_valid", {31'b0, out_valid}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("rst_hit_cnt", hit_cnt, 32'd0);
        check("rst_miss_cnt", miss_cnt, 32'd0);
`endif

        // Wrap and single-cycle miss on the second instance
        check("b_rst_pc", pc_b, 32'hFFFF_FFFC);
        rst = 1'b0; hit_b = 1'b1;
        step();
        check("b_wrap_pc", pc_b, 32'h0000_0000);
        check("b_wrap_out_pc", out_pc_b, 32'hFFFF_FFFC);
        step();
        check("b_pc4", pc_b, 32'h0000_0004);
        check("b_out_pc0", out_pc_b, 32'h0000_0000);
        hit_b = 1'b0;
        step();
        check("b_miss_stall", {31'b0, stall_b}, 32'd1);
        hit_b = 1'b1;
        step();
        check("b_one_cycle", {31'b0, stall_b}, 32'd0);
        check("b_retry_pc", pc_b, 32'h0000_0004);
        step();
        check("b_retry_out", out_pc_b, 32'h0000_0004);
        check("b_retry_instr", out_instr_b, instr_of(32'h0000_0004));
        check("b_retry_valid", {31'b0, out_valid_b}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
